sram_like_arbiter: RTL and testbench



---
 rtl/sram_like_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like slave port between two SRAM-like masters: the
//   instruction fetch (master I) and the MEM-stage data access (master D).
//   The address phase is granted by priority (D over I, with starvation
//   relief for I). The grant is held until the slave accepts the address.
//   An in-order owner FIFO steers each data_ok/rdata back to the master
//   that issued the transaction. Up to DEPTH transactions may be outstanding.
module sram_like_arbiter #(
    parameter int DEPTH      = 4,   // max outstanding transactions, power of 2 in 2..8
    parameter int STARVE_MAX = 4    // D grants allowed while I waits before I goes first
) (
    input  logic                       clk,
    input  logic                       rst,

    // master I (instruction fetch)
    input  logic                       i_req,
    input  logic                       i_wr,
    input  logic [1:0]                 i_size,
    input  logic [31:0]                i_addr,
    input  logic [31:0]                i_wdata,
    output logic [31:0]                i_rdata,
    output logic                       i_addr_ok,
    output logic                       i_data_ok,

    // master D (data access)
    input  logic                       d_req,
    input  logic                       d_wr,
    input  logic [1:0]                 d_size,
    input  logic [31:0]                d_addr,
    input  logic [31:0]                d_wdata,
    output logic [31:0]                d_rdata,
    output logic                       d_addr_ok,
    output logic                       d_data_ok,

    // shared slave port
    output logic                       s_req,
    output logic                       s_wr,
    output logic [1:0]                 s_size,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    input  logic [31:0]                s_rdata,
    input  logic                       s_addr_ok,
    input  logic                       s_data_ok,

    // status
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       protocol_err
);

    localparam int CW = $clog2(DEPTH + 1);       // occupancy counter width
    localparam int PW = $clog2(DEPTH);           // FIFO pointer width
    localparam int SW = $clog2(STARVE_MAX + 1);  // starve counter width

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

    // Which master a transaction belongs to; this is the bit stored in the owner FIFO.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Address-phase lock: once a request is on the slave port it stays there
    // until s_addr_ok, so the slave never sees the address change under it.
    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_I    = 2'd1,
        LK_D    = 2'd2
    } lock_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lock_e           lock_q,   lock_d;
    owner_e          fifo_q    [DEPTH];
    owner_e          fifo_d    [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            perr_q,   perr_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic            grant_vld;   // a master is routed to the slave this cycle
    owner_e          grant_own;   // which master is routed (also steers the s_* mux)
    logic            i_starved;   // I has waited through STARVE_MAX D grants
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;      // address accepted by slave: push owner
    logic            pop;         // data returned for a tracked transaction
    owner_e          head;        // owner of the oldest outstanding transaction

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign i_starved  = i_req && (starve_q == STARVE_SAT);
    assign head       = fifo_q[rd_ptr_q];

    // Arbitration: a held lock wins outright; otherwise D beats I unless I is starved.
    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_vld = 1'b0;
        grant_own = OWN_I;
        if (!rst) begin
            case (lock_q)
                LK_I: begin
                    grant_vld = 1'b1;
                    grant_own = OWN_I;
                end
                LK_D: begin
                    grant_vld = 1'b1;
                    grant_own = OWN_D;
                end
                default: begin
                    // A full FIFO blocks any new grant, even if a data_ok
                    // arrives this cycle: full never pushes and pops at once.
                    if (!fifo_full) begin
                        if (d_req && !i_starved) begin
                            grant_vld = 1'b1;
                            grant_own = OWN_D;
                        end else if (i_req) begin
                            grant_vld = 1'b1;
                            grant_own = OWN_I;
                        end
                    end
                end
            endcase
        end
    end

    // Slave-side mux: forward the selected master's address phase to the slave.
    always_comb begin
        s_req   = 1'b0;
        s_wr    = i_wr;
        s_size  = i_size;
        s_addr  = i_addr;
        s_wdata = i_wdata;
        if (grant_own == OWN_D) begin
            s_wr    = d_wr;
            s_size  = d_size;
            s_addr  = d_addr;
            s_wdata = d_wdata;
        end
        if (grant_vld) begin
            s_req = (grant_own == OWN_D) ? d_req : i_req;
        end
    end

    // Handshake routing: addr_ok to the granted master, data_ok to the FIFO head.
    assign accept    = s_req && s_addr_ok;
    assign i_addr_ok = accept && (grant_own == OWN_I);
    assign d_addr_ok = accept && (grant_own == OWN_D);

    assign pop       = !rst && s_data_ok && !fifo_empty;
    assign i_data_ok = pop && (head == OWN_I);
    assign d_data_ok = pop && (head == OWN_D);

    // Read data is broadcast; each master qualifies it with its own data_ok.
    assign i_rdata   = s_rdata;
    assign d_rdata   = s_rdata;

    assign outstanding  = cnt_q;
    assign protocol_err = perr_q;

    // Next state: lock, owner FIFO, pointers/occupancy, starve counter, error flag.
    always_comb begin
        lock_d   = LK_NONE;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        perr_d   = perr_q;

        // Lock the current owner while its request waits for s_addr_ok.
        if (s_req && !s_addr_ok) begin
            lock_d = (grant_own == OWN_D) ? LK_D : LK_I;
        end

        // Push the owner on address acceptance; pointers wrap modulo DEPTH.
        if (accept) begin
            fifo_d[wr_ptr_q] = grant_own;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Starve counter only measures D grants taken while I was asking.
        if (!i_req || (accept && grant_own == OWN_I)) begin
            starve_d = '0;
        end else if (accept && starve_q != STARVE_SAT) begin
            starve_d = starve_q + SW'(1);
        end

        // Data returned with nothing outstanding: slave broke ordering; sticky.
        if (s_data_ok && fifo_empty) begin
            perr_d = 1'b1;
        end
    end

    // Control state registers with synchronous active-high reset.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge value; the always_comb blocks above use blocking (=) because
    // they describe ordered combinational evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q   <= LK_NONE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            perr_q   <= perr_d;
        end
    end

    // Owner FIFO storage.
    // NOTE: storage is deliberately not reset; an entry is read only after the
    // occupancy count says it was written, so clearing pointers and count empties it.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter
//   Table-driven vectors, hand-written multi-cycle corner sequences and a
//   randomized phase, all checked every cycle against a transaction-level
//   reference model (owner queue, lock owner, starve count, sticky error).
module tb_sram_like_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 4;
    localparam int CW         = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_wr, d_req, d_wr;
    logic [1:0]    i_size, d_size;
    logic [31:0]   i_addr, i_wdata, d_addr, d_wdata;
    logic [31:0]   i_rdata, d_rdata;
    logic          i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic          s_req, s_wr;
    logic [1:0]    s_size;
    logic [31:0]   s_addr, s_wdata, s_rdata;
    logic          s_addr_ok, s_data_ok;
    logic [CW-1:0] outstanding;
    logic          protocol_err;

    always #5 clk = ~clk;

    sram_like_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .outstanding(outstanding), .protocol_err(protocol_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Owners: 0 = I, 1 = D. m_lock = -1 when no address phase is pending.
    int m_q[$];
    int m_lock   = -1;
    int m_starve = 0;
    bit m_perr   = 1'b0;

    // Expectations for the current cycle.
    bit e_sreq, e_acc, e_pop, e_idok, e_ddok;
    int e_own;

    // Let inputs settle, derive expectations from the rules, compare every output.
    task automatic settle_check();
        #4;
        e_sreq = 1'b0;
        e_own  = 0;
        if (!rst) begin
            if (m_lock >= 0) begin
                e_own  = m_lock;
                e_sreq = (m_lock == 1) ? d_req : i_req;
            end else if (m_q.size() < DEPTH) begin
                if (d_req && !(m_starve == STARVE_MAX && i_req)) begin
                    e_own = 1; e_sreq = 1'b1;
                end else if (i_req) begin
                    e_own = 0; e_sreq = 1'b1;
                end
            end
        end
        e_acc  = e_sreq && s_addr_ok;
        e_pop  = !rst && s_data_ok && (m_q.size() > 0);
        e_idok = e_pop && (m_q[0] == 0);
        e_ddok = e_pop && (m_q[0] == 1);

        check1("s_req", s_req, e_sreq);
        if (e_sreq) begin
            check32("s_addr",  s_addr,  (e_own == 1) ? d_addr  : i_addr);
            check32("s_wdata", s_wdata, (e_own == 1) ? d_wdata : i_wdata);
            check32("s_size",  32'(s_size), 32'((e_own == 1) ? d_size : i_size));
            check1 ("s_wr",    s_wr,    (e_own == 1) ? d_wr : i_wr);
        end
        check1("i_addr_ok", i_addr_ok, e_acc && e_own == 0);
        check1("d_addr_ok", d_addr_ok, e_acc && e_own == 1);
        check1("i_data_ok", i_data_ok, e_idok);
        check1("d_data_ok", d_data_ok, e_ddok);
        check32("outstanding", 32'(outstanding), m_q.size());
        check1("protocol_err", protocol_err, m_perr);
        if (e_idok) check32("i_rdata", i_rdata, s_rdata);
        if (e_ddok) check32("d_rdata", d_rdata, s_rdata);
    endtask

    // Clock edge: advance the model with the same inputs the DUT sampled.
    task automatic advance();
        bit empty_err;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_lock   = -1;
            m_starve = 0;
            m_perr   = 1'b0;
        end else begin
            empty_err = s_data_ok && (m_q.size() == 0);
            if (e_pop) void'(m_q.pop_front());
            if (e_acc) m_q.push_back(e_own);
            m_lock = (e_sreq && !s_addr_ok) ? e_own : -1;
            if (!i_req)                                m_starve = 0;
            else if (e_acc && e_own == 0)              m_starve = 0;
            else if (e_acc && m_starve < STARVE_MAX)   m_starve++;
            if (empty_err) m_perr = 1'b1;
        end
        #1;
    endtask

    task automatic cycle();
        settle_check();
        advance();
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; d_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        i_req, d_req;
        logic [31:0] i_addr, d_addr;
        logic        aok, dok;
        logic [31:0] rdata;
        logic        e_sreq;
        logic [31:0] e_saddr;
        logic        e_iaok, e_daok, e_idok, e_ddok;
        int          e_out;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    bit ip, dp;
    bit exp_d;

    initial begin
        // Simultaneous requests: D first, then I; data returns D then I.
        vecs[0]  = '{1'b1, 1'b0, 32'h1000, 32'h2000, 1'b1, 1'b0, 32'h0,         1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[0].d_req = 1'b1;
        vecs[1]  = '{1'b1, 1'b0, 32'h1000, 32'h2000, 1'b1, 1'b1, 32'h1111_0000, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[2]  = '{1'b0, 1'b0, 32'h1000, 32'h2000, 1'b0, 1'b1, 32'h2222_0000, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[3]  = '{1'b0, 1'b0, 32'h1000, 32'h2000, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 0};
        // Lock: I waits 3 cycles for addr_ok, D arrives in cycle 2 and must wait.
        vecs[4]  = '{1'b1, 1'b0, 32'h1004, 32'h2004, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b1, 1'b1, 32'h1004, 32'h2004, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b1, 32'h1004, 32'h2004, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b1, 1'b1, 32'h1004, 32'h2004, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1004, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 1'b1, 32'h1004, 32'h2004, 1'b1, 1'b0, 32'h0,         1'b1, 32'h2004, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b0, 32'h1004, 32'h2004, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[10] = '{1'b0, 1'b0, 32'h1004, 32'h2004, 1'b0, 1'b1, 32'h5A5A_0002, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[11] = '{1'b0, 1'b0, 32'h1004, 32'h2004, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 0};

        // Raw power-up reset before any checking (DUT state is unknown until then).
        rst = 1'b1;
        idle_inputs();
        i_wr = 1'b0; d_wr = 1'b0; i_size = 2'd2; d_size = 2'd2;
        i_addr = '0; d_addr = '0; i_wdata = 32'h0000_00AA; d_wdata = 32'h0000_00DD; s_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        do_reset();
        #4;
        check1("reset s_req", s_req, 1'b0);
        check32("reset outstanding", 32'(outstanding), 32'd0);
        check1("reset protocol_err", protocol_err, 1'b0);
        advance();

        // ---- table ----
        for (int k = 0; k < NV; k++) begin
            i_req = vecs[k].i_req;  d_req = vecs[k].d_req;
            i_addr = vecs[k].i_addr; d_addr = vecs[k].d_addr;
            s_addr_ok = vecs[k].aok; s_data_ok = vecs[k].dok; s_rdata = vecs[k].rdata;
            settle_check();
            check1($sformatf("v%0d s_req", k), s_req, vecs[k].e_sreq);
            if (vecs[k].e_sreq) check32($sformatf("v%0d s_addr", k), s_addr, vecs[k].e_saddr);
            check1($sformatf("v%0d i_addr_ok", k), i_addr_ok, vecs[k].e_iaok);
            check1($sformatf("v%0d d_addr_ok", k), d_addr_ok, vecs[k].e_daok);
            check1($sformatf("v%0d i_data_ok", k), i_data_ok, vecs[k].e_idok);
            check1($sformatf("v%0d d_data_ok", k), d_data_ok, vecs[k].e_ddok);
            check32($sformatf("v%0d outstanding", k), 32'(outstanding), 32'(vecs[k].e_out));
            if (vecs[k].e_idok) check32($sformatf("v%0d i_rdata", k), i_rdata, vecs[k].rdata);
            if (vecs[k].e_ddok) check32($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].rdata);
            advance();
        end

        // ---- full FIFO: no grant while full, even with data_ok the same cycle ----
        do_reset();
        d_addr = 32'h3000;
        for (int k = 0; k < DEPTH; k++) begin
            d_req = 1'b1; s_addr_ok = 1'b1;
            cycle();
        end
        i_req = 1'b1; d_req = 1'b1;
        settle_check();
        check1("full s_req", s_req, 1'b0);
        check32("full outstanding", 32'(outstanding), DEPTH);
        advance();
        s_data_ok = 1'b1;
        settle_check();
        check1("full+pop s_req", s_req, 1'b0);
        check1("full+pop d_data_ok", d_data_ok, 1'b1);
        check32("full+pop outstanding", 32'(outstanding), DEPTH);
        advance();
        s_data_ok = 1'b0;
        settle_check();
        check1("resume d_addr_ok", d_addr_ok, 1'b1);
        check32("resume outstanding", 32'(outstanding), DEPTH - 1);
        advance();
        idle_inputs();
        settle_check();
        check32("refill outstanding", 32'(outstanding), DEPTH);
        advance();

        // ---- starvation relief, zero-latency slave ----
        do_reset();
        i_addr = 32'h4000; d_addr = 32'h5000;
        i_req = 1'b1; d_req = 1'b1; s_addr_ok = 1'b1;
        for (int k = 0; k < 2 * (STARVE_MAX + 1); k++) begin
            s_data_ok = (m_q.size() > 0);
            settle_check();
            exp_d = ((k % (STARVE_MAX + 1)) != STARVE_MAX);
            check1($sformatf("starve pattern %0d d", k), d_addr_ok, exp_d);
            check1($sformatf("starve pattern %0d i", k), i_addr_ok, !exp_d);
            if (k == STARVE_MAX) check32("starve saturated", 32'(dut.starve_q), STARVE_MAX);
            advance();
        end

        // ---- protocol error: data_ok with nothing outstanding ----
        do_reset();
        s_data_ok = 1'b1;
        settle_check();
        check1("spurious i_data_ok", i_data_ok, 1'b0);
        check1("spurious d_data_ok", d_data_ok, 1'b0);
        advance();
        s_data_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle_check();
            check1($sformatf("perr sticky %0d", k), protocol_err, 1'b1);
            advance();
        end
        do_reset();
        settle_check();
        check1("perr cleared", protocol_err, 1'b0);
        advance();

        // ---- reset with two outstanding and a locked D request ----
        d_addr = 32'h6000; i_addr = 32'h7000;
        d_req = 1'b1; s_addr_ok = 1'b1; cycle();
        d_req = 1'b0; i_req = 1'b1;     cycle();
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h6004; s_addr_ok = 1'b0; cycle();
        settle_check();
        check32("pre-reset outstanding", 32'(outstanding), 32'd2);
        check32("pre-reset locked addr", s_addr, 32'h6004);
        advance();
        rst = 1'b1; s_data_ok = 1'b1;
        settle_check();
        check1("in-reset d_data_ok", d_data_ok, 1'b0);
        advance();
        rst = 1'b0; idle_inputs();
        settle_check();
        check1("post-reset s_req", s_req, 1'b0);
        check32("post-reset outstanding", 32'(outstanding), 32'd0);
        advance();
        i_req = 1'b1; i_addr = 32'h7100; s_addr_ok = 1'b1;
        settle_check();
        check32("post-reset fresh s_addr", s_addr, 32'h7100);
        check1("post-reset fresh i_addr_ok", i_addr_ok, 1'b1);
        advance();
        idle_inputs();
        cycle();

        // ---- randomized traffic against the model ----
        ip = 1'b0; dp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1'b1;
                i_addr = $urandom; i_wdata = $urandom;
                i_wr = ($urandom_range(0, 7) == 0);
                i_size = 2'($urandom_range(0, 2));
            end
            if (!dp && $urandom_range(0, 1) == 0) begin
                dp = 1'b1;
                d_addr = $urandom; d_wdata = $urandom;
                d_wr = ($urandom_range(0, 1) == 0);
                d_size = 2'($urandom_range(0, 2));
            end
            i_req = ip; d_req = dp;
            rst = ($urandom_range(0, 499) == 0);
            s_addr_ok = ($urandom_range(0, 3) != 0);
            s_data_ok = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 199) == 0);
            s_rdata = $urandom;
            settle_check();
            if (rst) begin
                ip = 1'b0; dp = 1'b0;
            end else begin
                if (e_acc && e_own == 0) ip = 1'b0;
                if (e_acc && e_own == 1) dp = 1'b0;
            end
            advance();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
